halfadder_bist: RTL and testbench
=================================

HALFADDER_BIST -- requirements
Module: halfadder_bist

Interface
REQ-001: Parameter SETTLE_CYCLES, default 2, number of extra cycles each vector is held before sampling (legal 0..15).
REQ-002: Parameter LOOPS, default 1, number of full 4-vector sweeps per run (legal 1..15).
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous and active-low.
REQ-005: start  input  1  run request; sampled only in IDLE.
REQ-006: A  output  1  stimulus bit A to the half adder under test.
REQ-007: B  output  1  stimulus bit B to the half adder under test.
REQ-008: C  input  1  carry returned by the half adder under test.
REQ-009: Sum  input  1  sum returned by the half adder under test.
REQ-010: busy  output  1  high while a run is in progress.
REQ-011: done  output  1  one-cycle pulse at end of run.
REQ-012: pass  output  1  run result: 1 means zero mismatches; held until next accepted start.
REQ-013: err_count  output  3  mismatching samples in last run, saturating.

Function
REQ-014: States IDLE, DRIVE, CHECK and DONE; IDLE→DRIVE on start=1; DONE→IDLE unconditionally after one cycle.
REQ-015: In IDLE, A=B=0 and busy=0; start in any state other than IDLE is ignored.
REQ-016: Accepting start clears err_count and pass and sets vector index and loop counter to 0; busy=1 from the next cycle.
REQ-017: Vectors apply in order {A,B}=00,01,10,11, and each is held for SETTLE_CYCLES+1 cycles.
REQ-018: On the last cycle of each hold, C SHALL be compared against A&B and Sum against A^B; either mismatch counts as one error.
REQ-019: err_count increments by 1 per mismatching vector and saturates at 7 (no wrap).
REQ-020: After vector 11, the loop counter increments; the block returns to vector 00 if the counter is below LOOPS, else goes to DONE.
REQ-021: Busy duration is exactly 4*LOOPS*(SETTLE_CYCLES+1) cycles.
REQ-022: In DONE, busy=0, done=1 for exactly one cycle, and A=B=0.
REQ-023: In DONE, pass=(err_count==0), valid from the done cycle and held until the next accepted start.
REQ-024: A comparison made in the same cycle as the final sample SHALL be included in err_count and pass as shown in the done cycle.
REQ-025: C and Sum are ignored outside the sample cycle.

Reset
REQ-026: rst_n=0 forces IDLE immediately, asynchronously and regardless of state, including mid-run.
REQ-027: Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, index and counters 0.
REQ-028: Deassertion of rst_n SHALL NOT start a run; an explicit start is required.

Configuration
REQ-029: Macro HALFADDER_BIST_ERRLOG_EN, when defined, adds output fail_vec (2 bits, the {A,B} of the first mismatching vector in the run) and output fail_seen (1 bit, set with it).
REQ-030: With HALFADDER_BIST_ERRLOG_EN, fail_vec and fail_seen reset to 0, clear on accepted start, and are captured only once per run.
REQ-031: Without HALFADDER_BIST_ERRLOG_EN, fail_vec and fail_seen and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032: Correct half adder, defaults, one start pulse -> busy for 12 cycles, done pulse on the next cycle, pass=1, err_count=0, fail_seen=0.
REQ-033: C stuck at 0 -> err_count=1, pass=0, fail_vec=2'b11.
REQ-034: Sum inverted, LOOPS=2 -> err_count=7 (saturated from 8), pass=0, fail_vec=2'b00.
REQ-035: Sum stuck at 0, SETTLE_CYCLES=0 -> busy for 4 cycles, err_count=2, fail_vec=2'b01; start pulses while busy do not restart or extend the run.
REQ-036: rst_n pulsed low in the 5th busy cycle -> all outputs 0 immediately, no done pulse; a following start with a correct adder gives pass=1, err_count=0.

Source files
------------

// File: rtl/halfadder_bist.sv
// Built-in self test for an external half adder: sweeps {A,B} through 00..11, samples C/Sum
// at the end of each hold and reports pass/err_count. Define HALFADDER_BIST_ERRLOG_EN for fail_vec/fail_seen.
module halfadder_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       C,
  input  logic       Sum,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
`ifdef HALFADDER_BIST_ERRLOG_EN
  ,
  output logic [1:0] fail_vec,
  output logic       fail_seen
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LP_LOOPS  = 4'(LOOPS);
  // With no settle cycles every hold is a single sample cycle, so DRIVE is skipped.
  localparam state_t LP_HOLD_ENTRY = (SETTLE_CYCLES == 0) ? S_CHECK : S_DRIVE;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_settle;
  logic [3:0] r_loop;
  logic [1:0] r_idx;
  logic [2:0] r_err;
  logic       r_pass;
  logic       w_busy;
  logic       w_mis;
  logic       w_last_vec;
  logic       w_more_loops;
  logic       w_run_end;
  logic [2:0] w_err_nxt;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign w_busy       = (r_state == S_DRIVE) || (r_state == S_CHECK);
  assign A            = w_busy & r_idx[1];
  assign B            = w_busy & r_idx[0];
  assign w_mis        = (r_state == S_CHECK) && ((C != (A & B)) || (Sum != (A ^ B)));
  assign w_err_nxt    = w_mis ? sat_inc(r_err) : r_err;
  assign w_last_vec   = (r_idx == 2'd3);
  assign w_more_loops = ((r_loop + 4'd1) < LP_LOOPS);
  assign w_run_end    = w_last_vec && !w_more_loops;

  assign busy      = w_busy;
  assign done      = (r_state == S_DONE);
  assign pass      = r_pass;
  assign err_count = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = LP_HOLD_ENTRY;
      S_DRIVE: if (r_settle == (LP_SETTLE - 4'd1)) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_run_end ? S_DONE : LP_HOLD_ENTRY;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= 4'd0;
      r_loop   <= 4'd0;
      r_idx    <= 2'd0;
      r_err    <= 3'd0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_settle <= 4'd0;
            r_loop   <= 4'd0;
            r_idx    <= 2'd0;
            r_err    <= 3'd0;
            r_pass   <= 1'b0;
          end
        end
        S_DRIVE: r_settle <= r_settle + 4'd1;
        S_CHECK: begin
          r_settle <= 4'd0;
          r_err    <= w_err_nxt;
          r_idx    <= r_idx + 2'd1;
          if (w_last_vec) r_loop <= r_loop + 4'd1;
          // The final sample lands in the same edge that enters DONE, so judge on the updated count.
          if (w_run_end) r_pass <= (w_err_nxt == 3'd0);
        end
        default: ;
      endcase
    end
  end

`ifdef HALFADDER_BIST_ERRLOG_EN
  logic [1:0] r_fail_vec;
  logic       r_fail_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_vec  <= 2'd0;
      r_fail_seen <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      r_fail_vec  <= 2'd0;
      r_fail_seen <= 1'b0;
    end else if (w_mis && !r_fail_seen) begin
      r_fail_vec  <= r_idx;
      r_fail_seen <= 1'b1;
    end
  end

  assign fail_vec  = r_fail_vec;
  assign fail_seen = r_fail_seen;
`endif

endmodule

// File: tb/tb_halfadder_bist.sv
// Scoreboard bench for halfadder_bist: three instances (defaults, LOOPS=2, SETTLE_CYCLES=0)
// driven by a behavioural half adder with selectable faults.
module tb_halfadder_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rstn_v, start_v, A_v, B_v, C_v, Sum_v, busy_v, done_v, pass_v;
  logic [2:0][2:0] err_v;
`ifdef HALFADDER_BIST_ERRLOG_EN
  logic [2:0][1:0] fv_v;
  logic [2:0]      fs_v;
`endif

  // 0 correct, 1 C stuck at 0, 2 Sum inverted, 3 Sum stuck at 0
  int mode;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         inst;
    int         busy;
    logic [2:0] err;
    logic       pass;
    logic [1:0] fv;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   busy_cnt[3];
  logic seq_bad[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign C_v[g]   = (mode == 1) ? 1'b0 : (A_v[g] & B_v[g]);
    assign Sum_v[g] = (mode == 2) ? ~(A_v[g] ^ B_v[g]) :
                      (mode == 3) ? 1'b0 : (A_v[g] ^ B_v[g]);
    halfadder_bist #(
      .SETTLE_CYCLES((g == 2) ? 0 : 2),
      .LOOPS        ((g == 1) ? 2 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rstn_v[g]),
      .start    (start_v[g]),
      .A        (A_v[g]),
      .B        (B_v[g]),
      .C        (C_v[g]),
      .Sum      (Sum_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .pass     (pass_v[g]),
      .err_count(err_v[g])
`ifdef HALFADDER_BIST_ERRLOG_EN
      ,
      .fail_vec (fv_v[g]),
      .fail_seen(fs_v[g])
`endif
    );
  end

  function automatic int settle_of(input int k);
    return (k == 2) ? 0 : 2;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: tracks busy length and vector order, pops the scoreboard on each done pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn_v[k]) begin
        busy_cnt[k] = 0;
        seq_bad[k]  = 1'b0;
      end else begin
        if (busy_v[k]) begin
          if ({A_v[k], B_v[k]} != 2'((busy_cnt[k] / (settle_of(k) + 1)) % 4)) seq_bad[k] = 1'b1;
          busy_cnt[k]++;
        end
        if (done_v[k]) begin
          if (exp_q.size() == 0) begin
            chk("done_expected", exp_q.size(), 1);
          end else begin
            e_mon = exp_q.pop_front();
            chk("done_inst", k, e_mon.inst);
            chk("busy_len", busy_cnt[k], e_mon.busy);
            chk("err_count", int'(err_v[k]), int'(e_mon.err));
            chk("pass", int'(pass_v[k]), int'(e_mon.pass));
            chk("busy_in_done", int'(busy_v[k]), 0);
            chk("ab_in_done", int'({A_v[k], B_v[k]}), 0);
            chk("vector_order", int'(seq_bad[k]), 0);
`ifdef HALFADDER_BIST_ERRLOG_EN
            chk("fail_vec", int'(fv_v[k]), int'(e_mon.fv));
            chk("fail_seen", int'(fs_v[k]), int'(e_mon.fs));
`endif
          end
          busy_cnt[k] = 0;
          seq_bad[k]  = 1'b0;
        end
      end
    end
  end

  task automatic run(input int k, input int m, input int bl, input int er, input int ps,
                     input int fv, input int fs, input bit extra_starts);
    exp_t x;
    int   n;
    mode   = m;
    x.inst = k;
    x.busy = bl;
    x.err  = 3'(er);
    x.pass = ps[0];
    x.fv   = 2'(fv);
    x.fs   = fs[0];
    exp_q.push_back(x);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    if (extra_starts) begin
      @(negedge clk);
      start_v[k] = 1'b1;
      repeat (2) @(negedge clk);
      start_v[k] = 1'b0;
    end
    n = 0;
    while (!done_v[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done_v[k]) begin
      chk("done_timeout", int'(done_v[k]), 1);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn_v  = 3'b000;
    start_v = 3'b000;
    mode    = 0;
    #12;
    for (int k = 0; k < 3; k++)
      chk("reset_outputs", int'({A_v[k], B_v[k], busy_v[k], done_v[k], pass_v[k], err_v[k]}), 0);
    @(negedge clk);
    rstn_v = 3'b111;
    repeat (3) @(negedge clk);
    chk("no_autostart", int'(busy_v), 0);

    run(0, 0, 12, 0, 1, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("pass_held", int'(pass_v[0]), 1);

    run(0, 1, 12, 1, 0, 3, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("pass_held_fail", int'(pass_v[0]), 0);
    chk("err_held", int'(err_v[0]), 1);

    run(1, 2, 24, 7, 0, 0, 1, 1'b0);
    run(2, 3, 4, 2, 0, 1, 1, 1'b1);

    // Reset asserted in the fifth busy cycle must abort the run with no done pulse.
    mode       = 0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", int'(busy_v[0]), 1);
    #2;
    rstn_v[0] = 1'b0;
    #1;
    chk("rst_outputs", int'({A_v[0], B_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0]}), 0);
    repeat (3) @(negedge clk);
    rstn_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_autostart_after_rst", int'(busy_v[0]), 0);

    run(0, 0, 12, 0, 1, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
